// File: rtl/exe_muldiv_ctrl.sv
// exe_muldiv_ctrl: iterative RV32M multiply/divide sequencer with pipeline stall and kill abort.
// Shift-add multiply and restoring divide share one accumulator; signs are restored at completion.
module exe_muldiv_ctrl #(
    parameter int ARCH_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_in,
    input  logic [2:0]          req_func3_in,
    input  logic [ARCH_LEN-1:0] req_op1_in,
    input  logic [ARCH_LEN-1:0] req_op2_in,
    input  logic                kill_in,
    output logic                stall_out,
    output logic                busy_out,
    output logic                result_valid_out,
    output logic [ARCH_LEN-1:0] result_out
);
    localparam int L  = ARCH_LEN;
    localparam int CW = $clog2(ARCH_LEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] count;
    logic [2:0]    func3;
    logic          neg1, neg2;
    logic [L-1:0]  opb;
    logic [2*L:0]  acc, acc_nxt, mul_nxt, div_nxt;

    logic          accept, special, last, div_zero, ovf;
    logic          s1, s2, n1_in, n2_in, div_neg;
    logic [L-1:0]  mag1, mag2, special_res, fin_res, quo, rem;
    logic [L:0]    mul_sum, div_sh;
    logic [L+1:0]  div_diff;
    logic [2*L-1:0] prod, sprod;

    always_comb begin
        accept      = (state == IDLE) & req_valid_in & ~kill_in;
        s1          = (req_func3_in[2] & ~req_func3_in[0]) | (~req_func3_in[2] & (req_func3_in[1] ^ req_func3_in[0]));
        s2          = (req_func3_in == 3'b001) | (req_func3_in[2] & ~req_func3_in[0]);
        n1_in       = s1 & req_op1_in[L-1];
        n2_in       = s2 & req_op2_in[L-1];
        mag1        = n1_in ? -req_op1_in : req_op1_in;
        mag2        = n2_in ? -req_op2_in : req_op2_in;
        div_zero    = req_op2_in == '0;
        ovf         = req_func3_in[2] & ~req_func3_in[0] & (req_op1_in == {1'b1, {(L-1){1'b0}}}) & (&req_op2_in);
        special     = req_func3_in[2] & (div_zero | ovf);
        special_res = div_zero ? (req_func3_in[1] ? req_op1_in : '1) : (req_func3_in[1] ? '0 : req_op1_in);
        // multiply: conditionally add multiplicand to the high half, then shift the whole product right
        mul_sum     = {1'b0, acc[2*L-1:L]} + (acc[0] ? {1'b0, opb} : '0);
        mul_nxt     = {1'b0, mul_sum, acc[L-1:1]};
        // divide: partial remainder in the high half, dividend shifting out / quotient shifting in below
        div_sh      = {acc[2*L-1:L], acc[L-1]};
        div_diff    = {1'b0, div_sh} - {2'b0, opb};
        div_neg     = div_diff[L+1];
        div_nxt     = {div_neg ? div_sh : div_diff[L:0], acc[L-2:0], ~div_neg};
        acc_nxt     = func3[2] ? div_nxt : mul_nxt;
        prod        = acc_nxt[2*L-1:0];
        sprod       = (neg1 ^ neg2) ? -prod : prod;
        quo         = acc_nxt[L-1:0];
        rem         = acc_nxt[2*L-1:L];
        fin_res     = func3[2] ? (func3[1] ? (neg1 ? -rem : rem) : ((neg1 ^ neg2) ? -quo : quo))
                               : ((func3[1:0] == 2'b00) ? sprod[L-1:0] : sprod[2*L-1:L]);
        last        = count == CW'(ARCH_LEN - 1);
        state_nxt   = kill_in ? IDLE :
                      (state == IDLE) ? (accept ? (special ? DONE : RUN) : IDLE) :
                      (state == RUN)  ? (last ? DONE : RUN) : IDLE;
        stall_out        = ~kill_in & (accept | (state == RUN));
        busy_out         = state != IDLE;
        result_valid_out = (state == DONE) & ~kill_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            func3      <= '0;
            neg1       <= 1'b0;
            neg2       <= 1'b0;
            opb        <= '0;
            acc        <= '0;
            result_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                func3 <= req_func3_in;
                neg1  <= n1_in;
                neg2  <= n2_in;
                opb   <= mag2;
                acc   <= {{(L+1){1'b0}}, mag1};
                count <= '0;
                if (special)
                    result_out <= special_res;
            end else if (state == RUN) begin
                acc   <= acc_nxt;
                count <= count + 1'b1;
                if (last && !kill_in)
                    result_out <= fin_res;
            end
        end
    end
endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// tb_exe_muldiv_ctrl: scoreboard bench for the RV32M multiply/divide sequencer.
module tb_exe_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_func3 = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic        kill = 1'b0;
    logic        stall, busy, result_valid;
    logic [31:0] result;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    exe_muldiv_ctrl #(.ARCH_LEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_in(req_valid),
        .req_func3_in(req_func3),
        .req_op1_in(req_op1),
        .req_op2_in(req_op2),
        .kill_in(kill),
        .stall_out(stall),
        .busy_out(busy),
        .result_valid_out(result_valid),
        .result_out(result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input int lat);
        int   edges;
        int   stalls;
        logic got;
        logic [31:0] want;
        @(negedge clk);
        req_valid = 1'b1;
        req_func3 = f3;
        req_op1   = a;
        req_op2   = b;
        exp_q.push_back(e);
        #1;
        stalls = int'(stall);
        edges  = 0;
        got    = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            req_valid = 1'b0;
            @(negedge clk);
            if (result_valid) got = 1'b1;
            else stalls += int'(stall);
        end
        chk($sformatf("done_seen f3=%0d", f3), 32'(got), 32'd1);
        if (got) begin
            chk($sformatf("latency f3=%0d", f3), 32'(edges), 32'(lat));
            chk($sformatf("stall_cycles f3=%0d", f3), 32'(stalls), 32'(lat));
            chk($sformatf("stall_in_done f3=%0d", f3), 32'(stall), 32'd0);
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk($sformatf("result f3=%0d a=%h b=%h", f3, a, b), result, want);
            last_exp = want;
        end
        @(negedge clk);
        chk($sformatf("pulse_end f3=%0d", f3), 32'(result_valid), 32'd0);
        chk($sformatf("idle_after f3=%0d", f3), 32'(busy), 32'd0);
        chk($sformatf("result_held f3=%0d", f3), result, e);
    endtask

    task automatic no_pulse(input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op(3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op(3'b001, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 33);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op(3'b101, 32'd100,      32'd7,        32'd14,        33);
        run_op(3'b111, 32'd100,      32'd7,        32'd2,         33);
        run_op(3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op(3'b111, 32'd5,        32'd0,        32'd5,         1);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);
        run_op(3'b100, 32'd7,        32'd0,        32'hFFFF_FFFF, 1);

        // kill ten cycles into a multiply
        @(negedge clk);
        req_valid = 1'b1; req_func3 = 3'b000; req_op1 = 32'd3; req_op2 = 32'd5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        #1;
        chk("kill_stall", 32'(stall), 32'd0);
        chk("kill_valid", 32'(result_valid), 32'd0);
        chk("kill_busy_same", 32'(busy), 32'd1);
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        chk("kill_busy_next", 32'(busy), 32'd0);
        chk("kill_result_kept", result, last_exp);
        no_pulse("kill_no_pulse", 40);

        // kill together with a request in IDLE is not accepted
        @(negedge clk);
        kill = 1'b1; req_valid = 1'b1; req_func3 = 3'b101; req_op1 = 32'd5; req_op2 = 32'd0;
        #1;
        chk("kill_req_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 begin kill = 1'b0; req_valid = 1'b0; end
        @(negedge clk);
        chk("kill_req_busy", 32'(busy), 32'd0);
        chk("kill_req_valid", 32'(result_valid), 32'd0);
        chk("kill_req_result", result, last_exp);

        // reset in the middle of a divide
        @(negedge clk);
        req_valid = 1'b1; req_func3 = 3'b100; req_op1 = 32'd100; req_op2 = 32'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(result_valid), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        no_pulse("rst_no_pulse", 40);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
